mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences a single-ported unified memory shared by the pipelined MIPS core's instruction-fetch (I) and data-access (D) ports.
- Replaces the separate imem/dmem pair with one memory behind this controller.
- Grants one outstanding access at a time, holds address/data stable for a fixed memory latency, and returns a one-cycle ready pulse with read data.
- Emits the stall signals the hazard unit uses to freeze the F and M stages.

Parameters:
- AW, 32, address width (byte address, passed through unchanged).
- DW, 32, data width.
- LATENCY, 2, memory cycles from mem_en rise to mem_rd valid; legal range 1..15.
- STARVE_MAX, 4, consecutive D grants allowed while I is waiting before I is forced; legal range >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  AW  fetch address.
- i_ready  out  1  one-cycle pulse; fetch complete.
- i_rdata  out  DW  fetched word; valid while i_ready.
- i_stall  out  1  i_req & ~i_ready (combinational).
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ready  out  1  one-cycle pulse; access complete.
- d_rdata  out  DW  load data; 0 for stores.
- d_stall  out  1  d_req & ~d_ready (combinational).
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data; valid in the LATENCY-th cycle of mem_en.
- perf_i_wait  out  32  I stall-cycle count (optional feature).
- perf_d_wait  out  32  D stall-cycle count (optional feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, d_streak 0.
- Reset is asynchronous: assertion forces all of the above immediately, including mid-access.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: arbitrates only here. On the clock edge with any request pending:
  - latch the winner, addr, we and wdata into registers;
  - load cnt = LATENCY-1;
  - go to ACCESS.
  - With no request pending, stay in IDLE.
- Priority: D over I (D belongs to the older instruction).
  - Exception: if i_req=1 and d_streak == STARVE_MAX, I wins.
- d_streak update:
  - +1 on each D grant made while i_req=1;
  - cleared on any I grant;
  - cleared on any D grant made while i_req=0;
  - saturates at STARVE_MAX.
- ACCESS:
  - mem_en=1; mem_addr and mem_wd driven from the latched registers and stable for all LATENCY cycles.
  - mem_we=1 only in the first ACCESS cycle, so exactly one write per store.
  - cnt decrements each cycle. When cnt==0, capture mem_rd (loads and fetches) or 0 (stores) into the response register and go to RESP.
- RESP:
  - winner's ready=1 for exactly one cycle, with rdata from the response register; mem_en=0.
  - Requests are ignored in this cycle; a still-high req is the one being answered.
  - Next state is always IDLE.
- Timing: request seen in IDLE at cycle 0 → ACCESS cycles 1..LATENCY → ready in cycle LATENCY+1 → IDLE in cycle LATENCY+2. Throughput is one access per LATENCY+2 cycles.
- Address, we and wdata changes on the requester side after the grant have no effect on the access in flight.
- A req that drops before its grant is never serviced. A req that drops after its grant still completes, with the ready pulse emitted.
- i_rdata and d_rdata hold their last value when ready is low; the bench checks them only under ready.
- Reset released mid-access: the aborted access produces no ready pulse. A still-pending req is re-arbitrated from IDLE.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: perf_i_wait and perf_d_wait increment on every cycle in which i_stall or d_stall (respectively) is 1. They saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Fetch only, LATENCY=2: i_req, i_addr=0x40 at cycle 0; mem word 0x8C020004 → mem_en in cycles 1-2 with mem_addr=0x40, i_ready in cycle 3 with i_rdata=0x8C020004, d_ready never asserted, state IDLE in cycle 4.
- Simultaneous i_req (0x44) and d_req (load 0x10) in cycle 0 → D granted first, d_ready in cycle 3; I granted in cycle 4, mem_en in cycles 5-6, i_ready in cycle 7.
- Store: d_req, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF → mem_we high only in cycle 1, d_ready in cycle 3 with d_rdata=0. A following load from 0x10 returns 0xDEADBEEF.
- Starvation, STARVE_MAX=4: d_req held continuously with i_req held → exactly 4 D ready pulses, then an I grant. d_streak reads 0 after the I grant.
- Reset asserted mid-cycle in ACCESS cycle 1 of a store → mem_en, mem_we and ready drop before the next edge; no ready pulse. After release with d_req still high, the store is re-run and completes LATENCY+1 cycles after the IDLE grant.
- With MEM_ARB_PERF_EN defined, the simultaneous-request scenario → perf_d_wait=3, perf_i_wait=7. Without the macro, both ports read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter for the I-fetch and D-access ports: one access at a time, D before I with a starvation guard.
// Optional MEM_ARB_PERF_EN builds saturating stall-cycle counters on perf_i_wait / perf_d_wait.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [31:0]   perf_i_wait,
    output logic [31:0]   perf_d_wait
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]      CNT_INIT   = 4'(LATENCY - 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [3:0]    cnt_r;
    logic          win_d_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] i_rdata_r;
    logic [DW-1:0] d_rdata_r;
    logic [SW-1:0] d_streak_r;
    logic          mem_en_r;
    logic          mem_we_r;
    logic          i_ready_r;
    logic          d_ready_r;
    logic          starve_s;
    logic          d_grant_s;
    logic          i_grant_s;

    // I is forced through once D has won STARVE_MAX times in a row over a waiting fetch
    assign starve_s  = i_req & (d_streak_r == STREAK_MAX);
    assign d_grant_s = d_req & ~starve_s;
    assign i_grant_s = i_req & ~d_grant_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req | d_req) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Grant latching, latency countdown, response capture and streak tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= 4'd0;
            win_d_r    <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {AW{1'b0}};
            wdata_r    <= {DW{1'b0}};
            i_rdata_r  <= {DW{1'b0}};
            d_rdata_r  <= {DW{1'b0}};
            d_streak_r <= {SW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_grant_s) begin
                        win_d_r <= 1'b1;
                        we_r    <= d_we;
                        addr_r  <= d_addr;
                        wdata_r <= d_wdata;
                        cnt_r   <= CNT_INIT;
                        if (!i_req) begin
                            d_streak_r <= {SW{1'b0}};
                        end else if (d_streak_r != STREAK_MAX) begin
                            d_streak_r <= d_streak_r + SW'(1'b1);
                        end else begin
                            d_streak_r <= d_streak_r;
                        end
                    end else if (i_grant_s) begin
                        win_d_r    <= 1'b0;
                        we_r       <= 1'b0;
                        addr_r     <= i_addr;
                        wdata_r    <= {DW{1'b0}};
                        cnt_r      <= CNT_INIT;
                        d_streak_r <= {SW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else if (win_d_r) begin
                        d_rdata_r <= we_r ? {DW{1'b0}} : mem_rd;
                    end else begin
                        i_rdata_r <= mem_rd;
                    end
                end
                RESP:    cnt_r <= 4'd0;
                default: cnt_r <= 4'd0;
            endcase
        end
    end

    // Output strobes registered from the next state so they align with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
        end else begin
            mem_en_r  <= (state_s == ACCESS);
            mem_we_r  <= (state_r == IDLE) & (state_s == ACCESS) & d_grant_s & d_we;
            i_ready_r <= (state_s == RESP) & ~win_d_r;
            d_ready_r <= (state_s == RESP) & win_d_r;
        end
    end

    assign mem_en   = mem_en_r;
    assign mem_we   = mem_we_r;
    assign mem_addr = addr_r;
    assign mem_wd   = wdata_r;
    assign i_ready  = i_ready_r;
    assign d_ready  = d_ready_r;
    assign i_rdata  = i_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign i_stall  = i_req & ~i_ready_r;
    assign d_stall  = d_req & ~d_ready_r;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_r;
    logic [31:0] perf_d_r;

    // Saturating stall-cycle counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_r <= 32'd0;
            perf_d_r <= 32'd0;
        end else begin
            if (i_stall && (perf_i_r != 32'hFFFF_FFFF)) begin
                perf_i_r <= perf_i_r + 32'd1;
            end
            if (d_stall && (perf_d_r != 32'hFFFF_FFFF)) begin
                perf_d_r <= perf_d_r + 32'd1;
            end
        end
    end

    assign perf_i_wait = perf_i_r;
    assign perf_d_wait = perf_d_r;
`else
    assign perf_i_wait = 32'd0;
    assign perf_d_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timeline reference model, directed scenarios and randomized traffic.
module tb_mem_arbiter;

    localparam int L  = 2;
    localparam int SM = 4;
`ifdef MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
    logic        i_ready, d_ready, i_stall, d_stall, mem_en, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd, mem_rd;
    logic [31:0] perf_i_wait, perf_d_wait;

    mem_arbiter #(.AW(32), .DW(32), .LATENCY(L), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h8C02_0004;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Memory device behind the arbiter
    logic [31:0] dev_mem [0:255];
    bit          dev_init = 1'b0;
    always @(posedge clk) begin
        if (!dev_init) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
            dev_init <= 1'b1;
        end else if (mem_we) begin
            dev_mem[mem_addr[9:2]] <= mem_wd;
        end
    end
    assign mem_rd = dev_mem[mem_addr[9:2]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int          ev_cyc[$];
    bit          ev_d[$];
    logic [31:0] ev_data[$];
    int          we_cyc[$];

    task automatic clear_logs();
        ev_cyc.delete(); ev_d.delete(); ev_data.delete(); we_cyc.delete();
    endtask

    // Reference model: each grant is a timeline (grant cycle g, access g+1..g+L, ready g+L+1)
    logic [31:0] ref_mem [0:255];
    bit          g_valid = 1'b0;
    int          g_cyc = 0;
    bit          g_is_d, g_we;
    logic [31:0] g_addr, g_wd, g_rdata;
    bit          hist[$];
    int          pi_cnt = 0, pd_cnt = 0;

    initial begin
        int  ph;
        bit  e_en, e_we, e_ir, e_dr, starved;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            #2;
            if (i_ready) begin ev_cyc.push_back(cyc); ev_d.push_back(1'b0); ev_data.push_back(i_rdata); end
            if (d_ready) begin ev_cyc.push_back(cyc); ev_d.push_back(1'b1); ev_data.push_back(d_rdata); end
            if (mem_we) we_cyc.push_back(cyc);
            if (reset) begin
                check("rst_i_ready", i_ready, 32'd0);
                check("rst_d_ready", d_ready, 32'd0);
                check("rst_mem_en", mem_en, 32'd0);
                check("rst_mem_we", mem_we, 32'd0);
                check("rst_mem_addr", mem_addr, 32'd0);
                check("rst_i_rdata", i_rdata, 32'd0);
                check("rst_d_rdata", d_rdata, 32'd0);
                check("rst_i_stall", i_stall, i_req);
                check("rst_d_stall", d_stall, d_req);
                check("rst_perf_i", perf_i_wait, 32'd0);
                check("rst_perf_d", perf_d_wait, 32'd0);
                g_valid = 1'b0;
                hist.delete();
                pi_cnt = 0;
                pd_cnt = 0;
            end else begin
                ph   = g_valid ? cyc - g_cyc : 0;
                e_en = g_valid && ph >= 1 && ph <= L;
                e_we = e_en && ph == 1 && g_we;
                e_ir = g_valid && ph == L + 1 && !g_is_d;
                e_dr = g_valid && ph == L + 1 && g_is_d;
                check("mem_en", mem_en, e_en);
                check("mem_we", mem_we, e_we);
                check("i_ready", i_ready, e_ir);
                check("d_ready", d_ready, e_dr);
                check("i_stall", i_stall, i_req & ~e_ir);
                check("d_stall", d_stall, d_req & ~e_dr);
                check("perf_i", perf_i_wait, PERF ? 32'(pi_cnt) : 32'd0);
                check("perf_d", perf_d_wait, PERF ? 32'(pd_cnt) : 32'd0);
                if (e_en) check("mem_addr", mem_addr, g_addr);
                if (e_we) check("mem_wd", mem_wd, g_wd);
                if (e_ir) check("i_rdata", i_rdata, g_rdata);
                if (e_dr) check("d_rdata", d_rdata, g_rdata);
                if (i_req & ~e_ir) pi_cnt++;
                if (d_req & ~e_dr) pd_cnt++;
                if (g_valid && ph == L + 1) begin
                    g_valid = 1'b0;
                end else if (!g_valid && (i_req || d_req)) begin
                    starved = i_req && (hist.size() == SM);
                    foreach (hist[k]) if (!hist[k]) starved = 1'b0;
                    g_valid = 1'b1;
                    g_cyc   = cyc;
                    if (d_req && !starved) begin
                        g_is_d  = 1'b1;
                        g_we    = d_we;
                        g_addr  = d_addr;
                        g_wd    = d_wdata;
                        g_rdata = d_we ? 32'd0 : ref_mem[d_addr[9:2]];
                        if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
                        hist.push_back(i_req);
                    end else begin
                        g_is_d  = 1'b0;
                        g_we    = 1'b0;
                        g_addr  = i_addr;
                        g_wd    = 32'd0;
                        g_rdata = ref_mem[i_addr[9:2]];
                        hist.push_back(1'b0);
                    end
                    if (hist.size() > SM) void'(hist.pop_front());
                end
            end
        end
    end

    task automatic tick(input bit drop_i, input bit drop_d);
        @(negedge clk);
        if (drop_i && i_ready) i_req = 1'b0;
        if (drop_d && d_ready) begin d_req = 1'b0; d_we = 1'b0; end
    endtask

    task automatic expect_ev(input string name, input int idx, input bit is_d, input int rel,
                             input int base, input logic [31:0] data);
        if (idx >= ev_cyc.size()) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no_event required=ready_at_+%0d", name, rel);
        end else begin
            check({name, "_who"}, ev_d[idx], is_d);
            check({name, "_cyc"}, ev_cyc[idx] - base, rel);
            check({name, "_data"}, ev_data[idx], data);
        end
    endtask

    function automatic logic [31:0] raddr();
        return {22'd0, 8'($urandom), 2'b00};
    endfunction

    initial begin
        int c0, r;
        logic [31:0] pi0, pd0;
        repeat (3) tick(1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) tick(1'b0, 1'b0);

        // fetch only
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        i_req = 1'b1; i_addr = 32'h40;
        repeat (6) tick(1'b1, 1'b1);
        check("t1_nev", ev_cyc.size(), 32'd1);
        expect_ev("t1_i", 0, 1'b0, 3, c0, 32'h8C02_0004);

        // simultaneous requests from a fresh reset
        tick(1'b1, 1'b1); reset = 1'b1;
        tick(1'b1, 1'b1); reset = 1'b0;
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        pi0 = perf_i_wait; pd0 = perf_d_wait;
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        repeat (10) tick(1'b1, 1'b1);
        check("t2_nev", ev_cyc.size(), 32'd2);
        expect_ev("t2_d", 0, 1'b1, 3, c0, 32'hA504_080C);
        expect_ev("t2_i", 1, 1'b0, 7, c0, 32'hA511_2233);
        check("t2_perf_d", perf_d_wait - pd0, PERF ? 32'd3 : 32'd0);
        check("t2_perf_i", perf_i_wait - pi0, PERF ? 32'd7 : 32'd0);

        // store then load-back
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        repeat (6) tick(1'b1, 1'b1);
        check("t3_nev", ev_cyc.size(), 32'd1);
        expect_ev("t3_st", 0, 1'b1, 3, c0, 32'd0);
        check("t3_we_n", we_cyc.size(), 32'd1);
        if (we_cyc.size() > 0) check("t3_we_cyc", we_cyc[0] - c0, 32'd1);
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        repeat (6) tick(1'b1, 1'b1);
        expect_ev("t3_ld", 0, 1'b1, 3, c0, 32'hDEAD_BEEF);

        // starvation guard with both requesters held
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        i_req = 1'b1; i_addr = 32'h48; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        repeat (42) tick(1'b0, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 10; k++)
            expect_ev($sformatf("t4_ev%0d", k), k, (k % 5) != 4, 3 + 4 * k, c0,
                      ((k % 5) != 4) ? 32'hA505_0A0F : 32'hA512_2436);
        repeat (4) tick(1'b0, 1'b0);

        // reset in the first access cycle of a store
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0; r = cyc;
        repeat (6) tick(1'b1, 1'b1);
        check("t5_nev", ev_cyc.size(), 32'd1);
        expect_ev("t5_rerun", 0, 1'b1, 3, r, 32'd0);
        check("t5_we_n", we_cyc.size(), 32'd1);
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        repeat (6) tick(1'b1, 1'b1);
        expect_ev("t5_ld", 0, 1'b1, 3, c0, 32'h1234_5678);

        // requests dropped right after arbitration
        tick(1'b1, 1'b1); c0 = cyc; clear_logs();
        i_req = 1'b1; i_addr = 32'h48; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        tick(1'b0, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        repeat (8) tick(1'b0, 1'b0);
        check("t6_nev", ev_cyc.size(), 32'd1);
        expect_ev("t6_d", 0, 1'b1, 3, c0, 32'hA505_0A0F);

        // randomized traffic with occasional reset pulses
        for (int n = 0; n < 2000; n++) begin
            tick(1'b0, 1'b0);
            reset = ($urandom_range(0, 149) == 0);
            if (!i_req || i_ready) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = raddr();
            end else if ($urandom_range(0, 3) == 0) begin
                i_addr = raddr();
            end
            if (!d_req || d_ready) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = raddr();
                d_wdata = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = raddr();
                d_wdata = $urandom;
            end
        end
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (8) tick(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
